aes_256_decrypt: RTL and testbench
==================================

// Module: aes_256_decrypt
// PURPOSE
//  Iterative AES-256 decryption core (FIPS-197 inverse cipher); receive-side counterpart of aes_256.
//  Accepts one 128-bit ciphertext block and a 256-bit key, then expands the key on chip.
//  Performs one inverse round per clock and returns the plaintext with a done strobe.
//  Sits after the link/storage path that carries aes_256 output; one block in flight at a time.
// PARAMETERS
//  NR          14  number of rounds; fixed at 14; elaboration error if any other value.
//  DONE_PULSE  1   1: done is a one-cycle pulse. 0: done holds high until the next accepted start.
// PORTS
//  clk         in   1    single clock; all state updates on the rising edge.
//  reset       in   1    asynchronous, active-high; clears all state immediately.
//  start       in   1    request; sampled only in IDLE.
//  ciphertext  in   128  input block; byte 0 = [127:120]; captured on accept.
//  key         in   256  cipher key; word w0 = [255:224]; captured on accept.
//  plaintext   out  128  result; valid while done is high and held until next result.
//  done        out  1    result-valid strobe; see DONE_PULSE.
//  busy        out  1    high from the cycle after accept until the cycle done rises.
// BEHAVIOUR
//  Reset values: plaintext=0, done=0, busy=0, FSM=IDLE, round counter=0, key-cache valid=0.
//  Round-key store: 15 x 128-bit registers rk[0..14]. rk0=key[255:128], rk1=key[127:0].
//  Key schedule, for k = 2..14, with t = last word of rk[k-1]:
//   - k even: word0 = rk[k-2].w0 ^ SubWord(RotWord(t)) ^ Rcon[k/2].
//   - k odd: word0 = rk[k-2].w0 ^ SubWord(t).
//   - words 1..3 chain as w[j] = rk[k-2].w[j] ^ w[j-1].
//  FSM states: IDLE -> KEXP -> ROUND -> IDLE.
//   - IDLE: start=1 at edge T is an accept. It latches ciphertext/key, writes rk0/rk1, sets kcnt=2, enters KEXP.
//   - KEXP: writes rk[kcnt] and increments kcnt, one per edge, at edges T+1..T+13.
//     At edge T+13 it writes rk14, loads st = ct ^ rk14 (forwarded, not re-read), sets r=13, enters ROUND.
//   - ROUND: r = 13..1 applies InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), then InvMixColumns.
//     r = 0 applies the same steps without InvMixColumns.
//     At edge T+27 the r=0 round loads plaintext, sets done=1, clears busy, and returns to IDLE.
//  Latency: accept at edge T gives done visible after edge T+27. Throughput is one block per 28 cycles.
//  Boundary conditions:
//   - start while busy: ignored; no effect on the latched block or key.
//   - start held high: a new accept occurs in the first IDLE cycle after done.
//     This accept may coincide with the done-rise edge +1 (back-to-back).
//   - start in the same cycle as a DONE_PULSE=0 done: accepted; done drops at that edge.
//   - ciphertext/key changing after accept: no effect.
//   - reset mid-operation: the operation is abandoned, outputs return to reset values, no done is issued.
//  All byte arithmetic is GF(2^8) mod x^8+x^4+x^3+x+1. Inverse S-box is a combinational table.
// CONFIGURATION
//  AES_DEC_KEY_CACHE_EN defined:
//   - After a completed KEXP, a cache-valid flag is set and the 256-bit key is retained.
//   - On accept with key equal to the cached key and cache valid: KEXP is skipped.
//     Edge T loads st = ct ^ rk14, r=13, enters ROUND. Done follows after edge T+14.
//   - On any key mismatch: normal KEXP path.
//   - Reset clears the cache.
//  AES_DEC_KEY_CACHE_EN undefined: no cache logic; every accept runs KEXP (27-cycle latency).
// TESTING
//  1. Key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> pt 00112233445566778899aabbccddeeff;
//     done exactly 27 cycles after accept; busy high for the same window.
//  2. Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
//     ct f3eed1bdb5d2a03c064b5a7e3db181f8 -> pt 6bc1bee22e409f96e93d7e117393172a.
//  3. Start pulsed at accept+5 with other ct/key -> ignored; result still as scenario 2.
//  4. Assert reset at accept+10 -> plaintext=0, done=0, busy=0 at once;
//     a fresh scenario-1 run afterwards passes.
//  5. Start held high across two blocks -> second accept at first IDLE cycle, both results correct;
//     DONE_PULSE=1 gives one-cycle done, DONE_PULSE=0 holds done until re-accept.
//  6. With AES_DEC_KEY_CACHE_EN: scenario 2 run twice -> second done 14 cycles after accept;
//     a new key -> 27 cycles; after reset the same key -> 27 cycles.

Source files
------------

// File: rtl/aes_256_decrypt.sv
// Iterative AES-256 inverse cipher: on-chip key expansion, then one inverse round per clock.
// Optional key cache (skips key expansion on a repeated key) enabled by AES_DEC_KEY_CACHE_EN.
module aes_256_decrypt #(
  parameter int unsigned NR         = 14,
  parameter int unsigned DONE_PULSE = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] ciphertext_i,
  input  logic [255:0] key_i,
  output logic [127:0] plaintext_o,
  output logic         done_o,
  output logic         busy_o
);

  if (NR != 14) begin : g_nr_check
    $error("aes_256_decrypt: NR must be 14");
  end

  localparam logic [2047:0] Sbox = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSbox = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {StIdle, StKexp, StRound} state_e;

  // Byte b of a table sits at bits [8*(255-b)+7 -: 8], i.e. index {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return Sbox[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSbox[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++) begin
      o[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return o;
  endfunction

  // Byte i of the state is row i%4, column i/4; InvShiftRows rotates row r right by r.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    t = t ^ rk;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
      end
    end
    return t;
  endfunction

  state_e       state_q;
  logic [3:0]   kcnt_q, rnd_q;
  logic [127:0] ct_q, st_q, plaintext_q;
  logic         done_q, busy_q;
  logic [127:0] rk_q [15];

  logic [127:0] rk_m1, rk_m2, rk_new, rnd_out;
  logic [31:0]  kt, ksw, kw0, kw1, kw2, kw3;
  logic [7:0]   rcon;
  logic         cache_hit;

  always_comb begin
    rk_m1 = rk_q[kcnt_q - 4'd1];
    rk_m2 = rk_q[kcnt_q - 4'd2];
    rcon  = 8'h01 << (kcnt_q[3:1] - 3'd1);
    kt    = rk_m1[31:0];
    if (kcnt_q[0]) ksw = sub_word(kt);
    else           ksw = sub_word({kt[23:0], kt[31:24]}) ^ {rcon, 24'h0};
    kw0   = rk_m2[127:96] ^ ksw;
    kw1   = rk_m2[95:64]  ^ kw0;
    kw2   = rk_m2[63:32]  ^ kw1;
    kw3   = rk_m2[31:0]   ^ kw2;
  end

  assign rk_new  = {kw0, kw1, kw2, kw3};
  assign rnd_out = inv_round(st_q, rk_q[rnd_q], rnd_q != 4'd0);

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid_q;

  // rk0/rk1 always hold the last accepted key, so they double as the cached key.
  assign cache_hit = cache_valid_q && (key_i == {rk_q[0], rk_q[1]});

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cache_valid_q <= 1'b0;
    end else if (state_q == StIdle && start_i && !cache_hit) begin
      cache_valid_q <= 1'b0;
    end else if (state_q == StKexp && kcnt_q == 4'(NR)) begin
      cache_valid_q <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      kcnt_q      <= '0;
      rnd_q       <= '0;
      ct_q        <= '0;
      st_q        <= '0;
      plaintext_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end else begin
      if (DONE_PULSE != 0) done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
            ct_q   <= ciphertext_i;
            if (cache_hit) begin
              st_q    <= ciphertext_i ^ rk_q[14];
              rnd_q   <= 4'(NR - 1);
              state_q <= StRound;
            end else begin
              rk_q[0] <= key_i[255:128];
              rk_q[1] <= key_i[127:0];
              kcnt_q  <= 4'd2;
              state_q <= StKexp;
            end
          end
        end
        StKexp: begin
          rk_q[kcnt_q] <= rk_new;
          kcnt_q       <= kcnt_q + 4'd1;
          if (kcnt_q == 4'(NR)) begin
            // Last round key is forwarded straight into the initial AddRoundKey.
            st_q    <= ct_q ^ rk_new;
            rnd_q   <= 4'(NR - 1);
            state_q <= StRound;
          end
        end
        StRound: begin
          st_q <= rnd_out;
          if (rnd_q == 4'd0) begin
            plaintext_q <= rnd_out;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign plaintext_o = plaintext_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_256_decrypt.sv
// Bench for aes_256_decrypt: pulse-done and hold-done instances against a transaction-level
// AES-256 decryption model, plus directed known-answer and latency checks.
module tb_aes_256_decrypt;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C2 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam int LatMiss = 27;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
  localparam int LatHit  = 14;
`else
  localparam bit CacheEn = 1'b0;
  localparam int LatHit  = 27;
`endif

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] ct = '0;
  logic [255:0] key = '0;
  logic [127:0] pt_p, pt_h;
  logic         done_p, done_h, busy_p, busy_h;
  int           total = 0, bad = 0;
  logic         chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_256_decrypt #(.NR(14), .DONE_PULSE(1)) u_dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .ciphertext_i(ct), .key_i(key),
    .plaintext_o(pt_p), .done_o(done_p), .busy_o(busy_p)
  );

  aes_256_decrypt #(.NR(14), .DONE_PULSE(0)) u_dut_hold (
    .clk_i(clk), .reset_i(rst), .start_i(start), .ciphertext_i(ct), .key_i(key),
    .plaintext_o(pt_h), .done_o(done_h), .busy_o(busy_h)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- GF(2^8) reference model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [255:0] k, input logic [127:0] c);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] s;
    logic [7:0]   b [16];
    logic [7:0]   nb [16];
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    s = c ^ {w[56], w[57], w[58], w[59]};
    for (int r = 13; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          nb[row+4*col] = isb[b[row+4*((col-row+4)%4)]];
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = nb[i];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[127-32*col -: 8];
          a1 = s[119-32*col -: 8];
          a2 = s[111-32*col -: 8];
          a3 = s[103-32*col -: 8];
          s[127-32*col -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[119-32*col -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[111-32*col -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[103-32*col -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    return s;
  endfunction

  // ---------------- transaction-level expectation ----------------
  logic [127:0] exp_pt = '0, m_pend = '0;
  logic [255:0] m_key = '0, m_ckey = '0;
  logic         exp_dp = 1'b0, exp_dh = 1'b0, exp_busy = 1'b0, m_infl = 1'b0, m_cval = 1'b0;
  logic         hit;
  int           m_edge = 0, m_done_edge = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pt = '0; exp_dp = 1'b0; exp_dh = 1'b0; exp_busy = 1'b0;
      m_infl = 1'b0; m_cval = 1'b0; m_edge = 0;
    end else begin
      m_edge++;
      exp_dp = 1'b0;
      if (m_infl && m_edge == m_done_edge) begin
        exp_pt = m_pend; exp_dp = 1'b1; exp_dh = 1'b1; m_infl = 1'b0;
        m_cval = 1'b1; m_ckey = m_key;
      end else if (!m_infl && start) begin
        hit         = CacheEn && m_cval && (key == m_ckey);
        m_done_edge = m_edge + (hit ? 14 : 27);
        m_pend      = model_dec(key, ct);
        m_key       = key;
        m_infl      = 1'b1;
        exp_dh      = 1'b0;
        if (!hit) m_cval = 1'b0;
      end
      exp_busy = m_infl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pt_pulse", 256'(pt_p), 256'(exp_pt));
      check("done_pulse", 256'(done_p), 256'(exp_dp));
      check("busy_pulse", 256'(busy_p), 256'(exp_busy));
      check("pt_hold", 256'(pt_h), 256'(exp_pt));
      check("done_hold", 256'(done_h), 256'(exp_dh));
      check("busy_hold", 256'(busy_h), 256'(exp_busy));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_block(input string nm, input logic [255:0] k, input logic [127:0] c,
                           input logic [127:0] p, input int lat, input int poke);
    int n = 0;
    @(negedge clk); key = k; ct = c; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done_p && n < 100) begin
      if (poke != 0 && n == poke - 1) begin
        start = 1'b1; key = ~k; ct = ~c;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); n++;
    end
    start = 1'b0;
    check({nm, "_latency"}, 256'(n), 256'(lat));
    check({nm, "_pt"}, 256'(pt_p), 256'(p));
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check({nm, "_rst_pt"}, 256'(pt_p), 256'(0));
    check({nm, "_rst_done"}, 256'(done_h), 256'(0));
    check({nm, "_rst_busy"}, 256'(busy_p), 256'(0));
    @(negedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    build_tables();
    chk_en = 1'b1;
    check("model_kat1", 256'(model_dec(K1, C1)), 256'(P1));
    check("model_kat2", 256'(model_dec(K2, C2)), 256'(P2));
    repeat (2) @(negedge clk);
    check("reset_pt", 256'(pt_p), 256'(0));
    check("reset_busy", 256'(busy_p), 256'(0));
    rst = 1'b0;

    run_block("s1", K1, C1, P1, LatMiss, 0);
    run_block("s2", K2, C2, P2, LatMiss, 0);
    run_block("s3", K2, C2, P2, LatHit, 5);

    // Reset ten cycles into a block: abandoned, then a fresh run succeeds.
    @(negedge clk); key = K1; ct = C1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("s4_busy_before", 256'(busy_p), 256'(1));
    pulse_reset("s4");
    run_block("s4_fresh", K1, C1, P1, LatMiss, 0);

    // Start held high across two blocks; second accept lands on the first IDLE cycle.
    @(negedge clk); key = K1; ct = C1; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done_p && n < 100) begin @(negedge clk); n++; end
    check("s5a_latency", 256'(n), 256'(LatHit));
    check("s5a_pt", 256'(pt_p), 256'(P1));
    key = K2; ct = C2;
    @(negedge clk);
    check("s5_b2b_busy", 256'(busy_p), 256'(1));
    check("s5_b2b_hold_drop", 256'(done_h), 256'(0));
    start = 1'b0;
    n = 0;
    while (!done_p && n < 100) begin @(negedge clk); n++; end
    check("s5b_latency", 256'(n), 256'(LatMiss));
    check("s5b_pt", 256'(pt_h), 256'(P2));

    run_block("s6_same", K2, C2, P2, LatHit, 0);
    run_block("s6_again", K2, C2, P2, LatHit, 0);
    run_block("s6_new", K1, C1, P1, LatMiss, 0);
    pulse_reset("s6");
    run_block("s6_after_rst", K1, C1, P1, LatMiss, 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
